// File: rtl/bus_cmd_ctrl_if.sv
// Bus-side signal bundle between the 8088 core and the bus command controller.
// The master modport is the CPU/clocking side, the slave modport is the controller.
interface bus_cmd_ctrl_if;
  logic        clk_en;
  logic [2:0]  s;
  logic [19:0] addr;
  logic        ale;
  logic        mrdc_n;
  logic        mwtc_n;
  logic        iorc_n;
  logic        iowc_n;
  logic        inta_n;
  logic        den;
  logic        dt_r;
  logic        ready;
  logic        halted;
  logic        busy;

  modport master (
    output clk_en, s, addr,
    input  ale, mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, den, dt_r, ready, halted, busy
  );

  modport slave (
    input  clk_en, s, addr,
    output ale, mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, den, dt_r, ready, halted, busy
  );
endinterface

// File: rtl/bus_cmd_ctrl.sv
// 8288-style bus command controller. Samples the 8088 status lines on each
// CPU clock tick, walks T1..T4 (with TW wait states and a HALT state) and
// drives ALE, the active-low bus commands, DEN, DT/R and the CPU READY line.
// All outputs are registered and only change on a clk edge with clk_en=1.
// Note: rst_n is active-high despite its name, matching the rest of the system.
module bus_cmd_ctrl #(
  parameter logic [2:0]  MEM_WS   = 3'd0,
  parameter logic [2:0]  ROM_WS   = 3'd1,
  parameter logic [2:0]  IO_WS    = 3'd1,
  parameter logic [2:0]  INTA_WS  = 3'd0,
  parameter logic [19:0] ROM_BASE = 20'hFC000
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_cmd_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_TW   = 3'd4,
    ST_T4   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CY_INTA = 3'd0,
    CY_IOR  = 3'd1,
    CY_IOW  = 3'd2,
    CY_MEMR = 3'd3,
    CY_MEMW = 3'd4
  } cyc_t;

  localparam logic [2:0] S_HALT    = 3'b011;
  localparam logic [2:0] S_PASSIVE = 3'b111;

  // Status code to cycle type; instruction fetch (100) runs as a memory read.
  function automatic cyc_t decode_status(input logic [2:0] st);
    cyc_t c;
    case (st)
      3'b000:  c = CY_INTA;
      3'b001:  c = CY_IOR;
      3'b010:  c = CY_IOW;
      3'b110:  c = CY_MEMW;
      default: c = CY_MEMR;
    endcase
    return c;
  endfunction

  // Wait states for the access class of a cycle; memory splits on the ROM window.
  function automatic logic [2:0] wait_states(input cyc_t c, input logic [19:0] a);
    logic [2:0] ws;
    case (c)
      CY_INTA:         ws = INTA_WS;
      CY_IOR, CY_IOW:  ws = IO_WS;
      CY_MEMR,
      CY_MEMW:         ws = (a >= ROM_BASE) ? ROM_WS : MEM_WS;
      default:         ws = MEM_WS;
    endcase
    return ws;
  endfunction

  // Active-high one-hot command select: bit0 INTA, 1 IORC, 2 IOWC, 3 MRDC, 4 MWTC.
  function automatic logic [4:0] cmd_onehot(input cyc_t c);
    logic [4:0] v;
    case (c)
      CY_INTA: v = 5'b00001;
      CY_IOR:  v = 5'b00010;
      CY_IOW:  v = 5'b00100;
      CY_MEMR: v = 5'b01000;
      CY_MEMW: v = 5'b10000;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

  function automatic logic is_write(input cyc_t c);
    return (c == CY_IOW) || (c == CY_MEMW);
  endfunction

  state_t     state_r, state_s;
  cyc_t       cyc_r, cyc_s;
  logic [2:0] wcnt_r, wcnt_s;
  logic       armed_r, armed_s;

  logic       ale_s, den_s, dt_r_s, ready_s, halted_s, busy_s;
  logic [4:0] cmd_s;
  logic       ale_r, den_r, dt_r_r, ready_r, halted_r, busy_r;
  logic [4:0] cmd_n_r;

  // State register: sequencer state, latched cycle type, wait counter, arm flag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
      cyc_r   <= CY_MEMR;
      wcnt_r  <= 3'd0;
      armed_r <= 1'b0;
    end else if (bus.clk_en) begin
      state_r <= state_s;
      cyc_r   <= cyc_s;
      wcnt_r  <= wcnt_s;
      armed_r <= armed_s;
    end
  end

  // Next-state logic: a cycle only starts after passive status has been seen.
  always_comb begin
    state_s = state_r;
    cyc_s   = cyc_r;
    wcnt_s  = wcnt_r;
    armed_s = armed_r;
    if (bus.clk_en) begin
      if (bus.s == S_PASSIVE) begin
        armed_s = 1'b1;
      end else begin
        armed_s = armed_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (armed_r && (bus.s == S_HALT)) begin
            state_s = ST_HALT;
            armed_s = 1'b0;
          end else if (armed_r && (bus.s != S_PASSIVE)) begin
            state_s = ST_T1;
            cyc_s   = decode_status(bus.s);
            armed_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_T1: begin
          wcnt_s  = wait_states(cyc_r, bus.addr);
          state_s = ST_T2;
        end
        ST_T2: begin
          state_s = ST_T3;
        end
        ST_T3, ST_TW: begin
          if (wcnt_r != 3'd0) begin
            state_s = ST_TW;
            wcnt_s  = wcnt_r - 3'd1;
          end else begin
            state_s = ST_T4;
          end
        end
        ST_T4: begin
          state_s = ST_IDLE;
        end
        ST_HALT: begin
          if (bus.s == S_PASSIVE) begin
            state_s = ST_IDLE;
          end else if (bus.s != S_HALT) begin
            state_s = ST_T1;
            cyc_s   = decode_status(bus.s);
            armed_s = 1'b0;
          end else begin
            state_s = ST_HALT;
          end
        end
        default: begin
          state_s = ST_IDLE;
          wcnt_s  = 3'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Output decode from the upcoming state so every output is a clean register.
  always_comb begin
    ale_s    = 1'b0;
    cmd_s    = 5'b00000;
    den_s    = 1'b0;
    dt_r_s   = 1'b1;
    ready_s  = 1'b1;
    halted_s = 1'b0;
    busy_s   = (state_s != ST_IDLE);
    case (state_s)
      ST_IDLE: begin
        dt_r_s = 1'b1;
      end
      ST_T1: begin
        ale_s  = 1'b1;
        dt_r_s = is_write(cyc_s);
      end
      ST_T2: begin
        cmd_s  = cmd_onehot(cyc_s);
        den_s  = 1'b1;
        dt_r_s = is_write(cyc_s);
      end
      ST_T3, ST_TW: begin
        cmd_s   = cmd_onehot(cyc_s);
        den_s   = 1'b1;
        dt_r_s  = is_write(cyc_s);
        ready_s = (wcnt_s == 3'd0);
      end
      ST_T4: begin
        dt_r_s = is_write(cyc_s);
      end
      ST_HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output registers, advanced only on CPU ticks.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ale_r    <= 1'b0;
      cmd_n_r  <= 5'b11111;
      den_r    <= 1'b0;
      dt_r_r   <= 1'b1;
      ready_r  <= 1'b1;
      halted_r <= 1'b0;
      busy_r   <= 1'b0;
    end else if (bus.clk_en) begin
      ale_r    <= ale_s;
      cmd_n_r  <= ~cmd_s;
      den_r    <= den_s;
      dt_r_r   <= dt_r_s;
      ready_r  <= ready_s;
      halted_r <= halted_s;
      busy_r   <= busy_s;
    end
  end

  assign bus.ale    = ale_r;
  assign bus.inta_n = cmd_n_r[0];
  assign bus.iorc_n = cmd_n_r[1];
  assign bus.iowc_n = cmd_n_r[2];
  assign bus.mrdc_n = cmd_n_r[3];
  assign bus.mwtc_n = cmd_n_r[4];
  assign bus.den    = den_r;
  assign bus.dt_r   = dt_r_r;
  assign bus.ready  = ready_r;
  assign bus.halted = halted_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_bus_cmd_ctrl.sv
// Scoreboard bench for bus_cmd_ctrl. Stimulus pushes the expected bus event
// (cycle class + wait states, or HALT) into a queue; a monitor rebuilds each
// observed cycle from the outputs tick by tick and compares its shape.
module tb_bus_cmd_ctrl;
  localparam logic [2:0]  MEM_WS   = 3'd0;
  localparam logic [2:0]  ROM_WS   = 3'd1;
  localparam logic [2:0]  IO_WS    = 3'd2;
  localparam logic [2:0]  INTA_WS  = 3'd0;
  localparam logic [19:0] ROM_BASE = 20'hFC000;
  localparam logic [2:0]  PAS      = 3'b111;

  logic clk = 1'b0;
  logic rst_n;
  bus_cmd_ctrl_if bus();

  bus_cmd_ctrl #(.MEM_WS(MEM_WS), .ROM_WS(ROM_WS), .IO_WS(IO_WS),
                 .INTA_WS(INTA_WS), .ROM_BASE(ROM_BASE))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #10 clk = ~clk;

  typedef struct {
    int kind;  // 0 bus cycle, 1 halt
    int cmd;   // 0 INTA, 1 IORC, 2 IOWC, 3 MRDC, 4 MWTC
    int ws;
    int dt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed_m = 1'b0;
  bit   halt_m  = 1'b0;

  logic [10:0] outs_w;
  assign outs_w = {bus.ale, bus.mrdc_n, bus.mwtc_n, bus.iorc_n, bus.iowc_n,
                   bus.inta_n, bus.den, bus.dt_r, bus.ready, bus.halted, bus.busy};

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: class and wait states straight from the status/address rules.
  function automatic exp_t expect_for(input logic [2:0] sv, input logic [19:0] av);
    exp_t e;
    int   memws;
    memws  = (av >= ROM_BASE) ? int'(ROM_WS) : int'(MEM_WS);
    e.kind = 0;
    case (sv)
      3'b000:  begin e.cmd = 0; e.ws = int'(INTA_WS); e.dt = 0; end
      3'b001:  begin e.cmd = 1; e.ws = int'(IO_WS);   e.dt = 0; end
      3'b010:  begin e.cmd = 2; e.ws = int'(IO_WS);   e.dt = 1; end
      3'b110:  begin e.cmd = 4; e.ws = memws;         e.dt = 1; end
      default: begin e.cmd = 3; e.ws = memws;         e.dt = 0; end
    endcase
    return e;
  endfunction

  // One CPU tick, preceded by 0..2 non-tick clocks carrying junk status.
  task automatic do_tick(input logic [2:0] sv, input logic [19:0] av);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      bus.s = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    bus.s      = sv;
    bus.addr   = av;
    bus.clk_en = 1'b1;
    @(negedge clk);
    bus.clk_en = 1'b0;
  endtask

  // Start tick plus the 4+WS ticks of the cycle; hold: 0 passive, 1 same status, 2 random.
  task automatic start_cycle(input logic [2:0] sv, input logic [19:0] av, input int hold);
    exp_t e;
    logic [2:0] ps;
    e = expect_for(sv, av);
    exp_q.push_back(e);
    do_tick(sv, av);
    armed_m = 1'b0;
    for (int i = 0; i < 4 + e.ws; i++) begin
      if (hold == 0)      ps = PAS;
      else if (hold == 1) ps = sv;
      else                ps = ($urandom_range(0, 1) == 1) ? PAS : sv;
      do_tick(ps, av);
      if (ps == PAS) armed_m = 1'b1;
    end
  endtask

  // Transaction-level model of how one status value at an idle point is handled.
  task automatic step(input logic [2:0] sv, input logic [19:0] av, input int hold);
    exp_t h;
    h.kind = 1; h.cmd = 0; h.ws = 0; h.dt = 1;
    if (halt_m) begin
      if (sv == PAS) begin
        do_tick(sv, av); halt_m = 1'b0; armed_m = 1'b1;
      end else if (sv == 3'b011) begin
        do_tick(sv, av);
      end else begin
        halt_m = 1'b0; start_cycle(sv, av, hold);
      end
    end else if (sv == PAS) begin
      do_tick(sv, av); armed_m = 1'b1;
    end else if (!armed_m) begin
      do_tick(sv, av);
    end else if (sv == 3'b011) begin
      exp_q.push_back(h); do_tick(sv, av); armed_m = 1'b0; halt_m = 1'b1;
    end else begin
      start_cycle(sv, av, hold);
    end
  endtask

  // Monitor state
  logic        tick_q = 1'b0;
  bit          in_cycle = 1'b0, in_halt = 1'b0, have_exp = 1'b0;
  exp_t        cur;
  int          len, ale_cnt, rdy_lo, den_cnt, halt_cnt, tot;
  int          cmd_cnt[5];
  bit          overlap, unstable;
  logic        dt0;
  logic [10:0] prev_v;
  logic [4:0]  cv;

  // Remember whether the last rising edge was a CPU tick.
  always @(posedge clk) tick_q <= bus.clk_en && !rst_n;

  // Monitor: rebuild cycles from outputs and score them against the queue.
  always @(negedge clk) begin
    cv = {~bus.mwtc_n, ~bus.mrdc_n, ~bus.iowc_n, ~bus.iorc_n, ~bus.inta_n};
    if (rst_n) begin
      in_cycle = 1'b0;
      in_halt  = 1'b0;
      prev_v   = outs_w;
    end else if (!tick_q) begin
      chk("hold_between_ticks", int'(outs_w), int'(prev_v));
    end else begin
      prev_v = outs_w;
      if (!in_cycle && bus.ale) begin
        in_cycle = 1'b1;
        len = 0; ale_cnt = 0; rdy_lo = 0; den_cnt = 0; halt_cnt = 0;
        for (int i = 0; i < 5; i++) cmd_cnt[i] = 0;
        overlap = 1'b0; unstable = 1'b0; dt0 = bus.dt_r;
        if (exp_q.size() == 0) begin
          have_exp = 1'b0;
          chk("unexpected_cycle", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          have_exp = 1'b1;
          chk("event_kind_cycle", cur.kind, 0);
        end
      end
      if (in_cycle) begin
        if (bus.busy) begin
          len++;
          ale_cnt  += int'(bus.ale);
          rdy_lo   += int'(!bus.ready);
          den_cnt  += int'(bus.den);
          halt_cnt += int'(bus.halted);
          for (int i = 0; i < 5; i++) cmd_cnt[i] += int'(cv[i]);
          if (bus.ale && (cv != 5'b00000)) overlap = 1'b1;
          if (bus.dt_r != dt0) unstable = 1'b1;
        end else begin
          in_cycle = 1'b0;
          if (have_exp && cur.kind == 0) begin
            tot = 0;
            for (int i = 0; i < 5; i++) tot += cmd_cnt[i];
            chk("ale_ticks", ale_cnt, 1);
            chk("cmd_width", cmd_cnt[cur.cmd], 2 + cur.ws);
            chk("cmd_total", tot, 2 + cur.ws);
            chk("ready_low_ticks", rdy_lo, cur.ws);
            chk("den_ticks", den_cnt, 2 + cur.ws);
            chk("cycle_len", len, 4 + cur.ws);
            chk("dt_r_value", int'(dt0), cur.dt);
            chk("dt_r_stable", int'(unstable), 0);
            chk("ale_cmd_overlap", int'(overlap), 0);
            chk("halted_in_cycle", halt_cnt, 0);
          end
          chk("idle_dt_r", int'(bus.dt_r), 1);
        end
      end
      if (bus.halted) begin
        if (!in_halt) begin
          in_halt = 1'b1;
          if (exp_q.size() == 0) chk("unexpected_halt", 1, 0);
          else begin
            cur = exp_q.pop_front();
            chk("event_kind_halt", cur.kind, 1);
          end
        end
        chk("halt_quiet", int'({cv, bus.den}), 0);
      end else begin
        in_halt = 1'b0;
      end
    end
  end

  // Hard time bound on the whole run.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Directed scenarios followed by randomized status traffic.
  initial begin
    exp_t e;
    logic [2:0]  sv;
    logic [19:0] av;
    rst_n      = 1'b1;
    bus.clk_en = 1'b0;
    bus.s      = PAS;
    bus.addr   = 20'h00000;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outs_w), int'(11'b01111101100));
    rst_n = 1'b0;
    @(negedge clk);

    // Reset in the middle of an I/O read wait state.
    step(PAS, 20'h00000, 0);
    e = expect_for(3'b001, 20'h00060);
    exp_q.push_back(e);
    do_tick(3'b001, 20'h00060);
    armed_m = 1'b0;
    repeat (3) do_tick(3'b001, 20'h00060);
    chk("tw_iorc_active", int'(bus.iorc_n), 0);
    chk("tw_ready_low", int'(bus.ready), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_iorc_n", int'(bus.iorc_n), 1);
    chk("rst_den", int'(bus.den), 0);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk); #2 rst_n = 1'b0;
    armed_m = 1'b0;
    halt_m  = 1'b0;
    @(negedge clk);
    step(3'b001, 20'h00060, 0);
    step(3'b001, 20'h00060, 0);
    chk("no_cycle_unarmed_after_reset", int'(bus.busy), 0);

    // Memory reads (RAM, ROM) and an I/O write.
    step(PAS, 20'h00000, 0); step(3'b101, 20'h00100, 0);
    step(PAS, 20'h00000, 0); step(3'b101, 20'hFFFF0, 0);
    step(PAS, 20'h00000, 0); step(3'b010, 20'h00043, 0);

    // Two INTA cycles separated by passive, then held status gives no retrigger.
    step(PAS, 20'h00000, 0); step(3'b000, 20'h00000, 1);
    step(PAS, 20'h00000, 0); step(3'b000, 20'h00000, 1);
    step(3'b000, 20'h00000, 1);
    step(3'b000, 20'h00000, 1);
    chk("inta_no_retrigger", int'(bus.busy), 0);

    // HALT, then an I/O read straight out of HALT.
    step(PAS, 20'h00000, 0); step(3'b011, 20'h00000, 0);
    step(3'b011, 20'h00000, 0); step(3'b011, 20'h00000, 0);
    chk("halted_flag", int'(bus.halted), 1);
    step(3'b001, 20'h00021, 0);
    chk("halt_exit_cleared", int'(bus.halted), 0);

    // Randomized status traffic.
    for (int n = 0; n < 250; n++) begin
      sv = ($urandom_range(0, 9) < 4) ? PAS : 3'($urandom_range(0, 7));
      av = ($urandom_range(0, 1) == 1) ? (ROM_BASE + 20'($urandom_range(0, 16383)))
                                      : 20'($urandom);
      step(sv, av, $urandom_range(0, 2));
    end

    repeat (4) step(PAS, 20'h00000, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("cycle_closed", int'(in_cycle), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
